// File: rtl/nmr_bstrm_simp_cnt.sv
// nmr_bstrm_simp_cnt
// -----------------------------------------------------------------------------
// SRAM-driven NMR bitstream sequencer. After START, it reads 32-bit command
// words from the pulse-program RAM, starting at address 0. For each word it
// holds OUT at the word's polarity for the programmed number of cycles. The
// sequence ends on a word with seq_end set, and DONE then stays high until
// the next accepted START.
//
// Word layout:
//   [31] pls_pol   [30] seq_end   [29] loop_sta   [28] loop_sto
//   [27:24] mux_sel (latched only)   [DATA_WIDTH-1:0] data
//
// Optional feature macro: BSTRM_LOOP_EN
//   When this macro is defined, the design supports one level of hardware
//   looping through the loop_sta and loop_sto bits. When it is undefined,
//   both loop bits are ignored, no loop registers are built, and the program
//   runs strictly in address order.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-low reset
//   START        in   level, sampled while idle or finished
//   DONE         out  high from sequence end until the next accepted START
//   OUT          out  bitstream output
//   SRAM_ADDR    out  RAM word address
//   SRAM_CS      out  RAM read strobe (high for both fetch cycles)
//   SRAM_RD_DAT  in   RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module nmr_bstrm_simp_cnt #(
    parameter int CMD_WIDTH       = 8,
    parameter int LOOP_WIDTH      = 24,
    parameter int SRAM_ADDR_WIDTH = 8,
    parameter int SRAM_DAT_WIDTH  = 32,
    parameter int DATA_WIDTH      = 24,
    parameter int MUX_WIDTH       = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    output logic                       DONE,
    output logic                       OUT,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_CS,
    input  logic [SRAM_DAT_WIDTH-1:0]  SRAM_RD_DAT
);

    localparam int MUX_BITS = $clog2(MUX_WIDTH);
    // The program counter lives in the RAM address space. CMD_WIDTH only has
    // to cover that space.
    localparam int UNUSED_CMD_WIDTH = CMD_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, END} state_t;

    state_t                      state_reg, state_next;
    logic                        fetch_second_reg;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0]       dur_cnt_reg;
    logic                        seq_end_reg;
    logic [MUX_BITS-1:0]         mux_sel_reg;
    logic                        out_reg;
    logic                        done_reg;

    // Field view of the word currently presented by the RAM
    logic                        w_pol, w_seq_end;
    logic [DATA_WIDTH-1:0]       w_data, w_dur;

    assign w_pol     = SRAM_RD_DAT[31];
    assign w_seq_end = SRAM_RD_DAT[30];
    assign w_data    = SRAM_RD_DAT[DATA_WIDTH-1:0];
    // A zero duration still costs one EXEC cycle.
    assign w_dur     = (w_data == '0) ? DATA_WIDTH'(1) : w_data;

    logic fetch_done, exec_last;
    assign fetch_done = (state_reg == FETCH) && fetch_second_reg;
    assign exec_last  = (state_reg == EXEC) && (dur_cnt_reg == DATA_WIDTH'(1));

    logic                        is_loop_sta;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_after_exec;

`ifdef BSTRM_LOOP_EN
    logic [LOOP_WIDTH-1:0]       loop_cnt_reg, loop_cnt_dec, w_loop_cnt;
    logic [SRAM_ADDR_WIDTH-1:0]  loop_addr_reg;
    logic                        loop_sto_reg;

    // A loop_sta word that also carries seq_end runs as an ordinary final word.
    assign is_loop_sta     = SRAM_RD_DAT[29] && !w_seq_end;
    assign w_loop_cnt      = (LOOP_WIDTH'(w_data) == '0) ? LOOP_WIDTH'(1)
                                                         : LOOP_WIDTH'(w_data);
    assign loop_cnt_dec    = loop_cnt_reg - LOOP_WIDTH'(1);
    assign addr_after_exec = (loop_sto_reg && (loop_cnt_dec != '0))
                           ? loop_addr_reg : addr_reg + SRAM_ADDR_WIDTH'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            loop_cnt_reg  <= '0;
            loop_addr_reg <= '0;
            loop_sto_reg  <= 1'b0;
        end else begin
            if (fetch_done) begin
                if (is_loop_sta) begin
                    loop_cnt_reg  <= w_loop_cnt;
                    loop_addr_reg <= addr_reg + SRAM_ADDR_WIDTH'(1);
                end else begin
                    loop_sto_reg  <= SRAM_RD_DAT[28];
                end
            end
            // seq_end wins over loop_sto, so the count is left alone then.
            if (exec_last && !seq_end_reg && loop_sto_reg) begin
                loop_cnt_reg <= loop_cnt_dec;
            end
        end
    end
`else
    assign is_loop_sta     = 1'b0;
    assign addr_after_exec = addr_reg + SRAM_ADDR_WIDTH'(1);
`endif

    // FSM: state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, END: if (START) state_next = FETCH;
            FETCH:     if (fetch_second_reg) state_next = is_loop_sta ? FETCH : EXEC;
            EXEC:      if (exec_last) state_next = seq_end_reg ? END : FETCH;
            default:   state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        SRAM_CS = (state_reg == FETCH);
    end

    assign SRAM_ADDR = addr_reg;
    assign OUT       = out_reg;
    assign DONE      = done_reg;

    // Datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_second_reg <= 1'b0;
            addr_reg         <= '0;
            dur_cnt_reg      <= '0;
            seq_end_reg      <= 1'b0;
            mux_sel_reg      <= '0;
            out_reg          <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, END: begin
                    if (START) begin
                        done_reg         <= 1'b0;
                        addr_reg         <= '0;
                        fetch_second_reg <= 1'b0;
                    end
                end
                FETCH: begin
                    // The address is held for both strobe cycles. The word is
                    // taken on the second edge.
                    fetch_second_reg <= !fetch_second_reg;
                    if (fetch_second_reg) begin
                        mux_sel_reg <= SRAM_RD_DAT[24 +: MUX_BITS];
                        if (is_loop_sta) begin
                            addr_reg <= addr_reg + SRAM_ADDR_WIDTH'(1);
                        end else begin
                            out_reg     <= w_pol;
                            seq_end_reg <= w_seq_end;
                            dur_cnt_reg <= w_dur;
                        end
                    end
                end
                EXEC: begin
                    if (exec_last) begin
                        if (seq_end_reg) begin
                            out_reg  <= 1'b0;
                            done_reg <= 1'b1;
                        end else begin
                            addr_reg <= addr_after_exec;
                        end
                    end else begin
                        dur_cnt_reg <= dur_cnt_reg - DATA_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The mux selection is kept for a future mux port. The loop bits have no
    // reader in a linear-only build.
    logic unused_bits;
    assign unused_bits = ^{SRAM_RD_DAT[29:28], mux_sel_reg, UNUSED_CMD_WIDTH[0]};

endmodule

// File: tb/tb_nmr_bstrm_simp_cnt.sv
// Testbench for nmr_bstrm_simp_cnt.
//
// The stimulus process loads programs into a RAM model. From the word rules,
// it computes the complete per-cycle response expected from the first fetch
// cycle onward, and queues that response. A separate monitor pops one
// expected entry on every falling edge while entries are pending. It compares
// the entry against SRAM_CS, SRAM_ADDR (during fetch), OUT and DONE.
module tb_nmr_bstrm_simp_cnt;

`ifdef BSTRM_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif
    localparam int TAIL = 3;     // DONE cycles checked after each sequence

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        DONE, OUT, SRAM_CS;
    logic [7:0]  SRAM_ADDR;
    logic [31:0] SRAM_RD_DAT;

    nmr_bstrm_simp_cnt dut (
        .CLK(CLK), .RST(RST), .START(START), .DONE(DONE), .OUT(OUT),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CS(SRAM_CS), .SRAM_RD_DAT(SRAM_RD_DAT)
    );

    always #5 CLK = ~CLK;

    // Registered-read RAM model
    logic [31:0] mem [0:255];
    always @(posedge CLK) if (SRAM_CS) SRAM_RD_DAT <= mem[SRAM_ADDR];

    typedef struct packed {
        logic       cs;
        logic [7:0] addr;
        logic       out;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t model_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: decoupled from stimulus
    always @(negedge CLK) begin
        exp_t e;
        logic [10:0] act, req;
        if (RST && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_no++;
            req = {e.cs, e.cs ? e.addr : 8'h00, e.out, e.done};
            act = {SRAM_CS, e.cs ? SRAM_ADDR : 8'h00, OUT, DONE};
            check($sformatf("trace_cyc%0d{cs,addr,out,done}", cyc_no), {21'd0, act}, {21'd0, req});
        end
    end

    function automatic logic [31:0] mkw(input bit pol, input bit send, input bit lsta,
                                        input bit lsto, input logic [3:0] mux, input int d);
        logic [23:0] d24;
        d24 = d[23:0];
        return {pol, send, lsta, lsto, mux, d24};
    endfunction

    // Reference model: walks the program as the word rules describe and lists
    // what each cycle should look like, starting at the first fetch cycle.
    task automatic build_model();
        int pc, lcnt, laddr, d, steps;
        bit prev;
        logic [31:0] w;
        pc = 0; lcnt = 0; laddr = 0; steps = 0; prev = 1'b0;
        model_q.delete();
        while (steps < 300) begin
            steps++;
            w = mem[pc];
            repeat (2) model_q.push_back('{cs: 1'b1, addr: pc[7:0], out: prev, done: 1'b0});
            d = int'(w[23:0]);
            if (LOOP_EN && w[29] && !w[30]) begin
                lcnt  = (d == 0) ? 1 : d;
                pc    = (pc + 1) % 256;
                laddr = pc;
                continue;
            end
            if (d == 0) d = 1;
            repeat (d) model_q.push_back('{cs: 1'b0, addr: 8'h00, out: w[31], done: 1'b0});
            prev = w[31];
            if (w[30]) begin
                repeat (TAIL) model_q.push_back('{cs: 1'b0, addr: 8'h00, out: 1'b0, done: 1'b1});
                break;
            end
            if (LOOP_EN && w[28]) begin
                lcnt = (lcnt - 1) & 32'h00FF_FFFF;
                pc   = (lcnt != 0) ? laddr : (pc + 1) % 256;
            end else begin
                pc = (pc + 1) % 256;
            end
        end
    endtask

    task automatic load(input logic [31:0] words[$]);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        foreach (words[i]) mem[i] = words[i];
    endtask

    // Start one sequence; optionally pulse START again while it is running.
    task automatic run_prog(input string tag, input bit pulse_start);
        int cyc;
        build_model();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        $display("run %s: %0d expected cycles", tag, model_q.size());
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(posedge CLK);
            #1;
            START = (pulse_start && exp_q.size() > TAIL + 4 && $urandom_range(0, 5) == 0);
            cyc++;
        end
        START = 1'b0;
        check({"drain_", tag}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [31:0] prog[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ls, lo;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_out", OUT, 0);
        check("rst_done", DONE, 0);
        check("rst_cs", SRAM_CS, 0);
        check("rst_addr", SRAM_ADDR, 0);
        RST = 1'b1;

        // Linear program: DONE lands 84 cycles after the first fetch
        prog = '{mkw(1,0,0,0,4'h3,20), mkw(0,0,0,0,4'h0,20), mkw(1,0,0,0,4'h5,20), mkw(0,1,0,0,4'h0,16)};
        load(prog);
        run_prog("linear", 1'b0);

        // Zero duration
        prog = '{mkw(1,0,0,0,4'h0,0), mkw(0,0,0,0,4'h0,2), mkw(1,1,0,0,4'h0,0)};
        load(prog);
        run_prog("zero_dur", 1'b0);

        // Loop program (linear when the loop feature is absent)
        prog = '{mkw(0,0,1,0,4'h0,3), mkw(1,0,0,0,4'h0,5), mkw(0,0,0,1,4'h0,5), mkw(0,1,0,0,4'h0,1)};
        load(prog);
        run_prog("loop", 1'b0);

        // START while running is ignored; START while DONE restarts
        prog = '{mkw(1,0,0,0,4'h3,20), mkw(0,0,0,0,4'h0,20), mkw(1,0,0,0,4'h5,20), mkw(0,1,0,0,4'h0,16)};
        load(prog);
        run_prog("linear_startpulse", 1'b1);
        run_prog("restart_from_done", 1'b1);

        // Reset in the middle of the second word's EXEC
        build_model();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        repeat (30) @(posedge CLK);
        #2 RST = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out", OUT, 0);
        check("midrst_done", DONE, 0);
        check("midrst_cs", SRAM_CS, 0);
        check("midrst_addr", SRAM_ADDR, 0);
        repeat (3) begin
            @(negedge CLK);
            check("midrst_hold_cs", SRAM_CS, 0);
        end
        RST = 1'b1;
        run_prog("after_reset", 1'b0);

        // Randomized programs
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 6);
            prog.delete();
            for (int i = 0; i < n; i++)
                prog.push_back(mkw($urandom_range(0, 1), (i == n - 1), 0, 0,
                                   4'($urandom_range(0, 15)), $urandom_range(0, 5)));
            if (n >= 3 && $urandom_range(0, 1) == 1) begin
                ls = $urandom_range(0, n - 3);
                lo = $urandom_range(ls + 1, n - 2);
                prog[ls][29] = 1'b1;
                prog[ls][23:0] = 24'($urandom_range(0, 3));
                prog[lo][28] = 1'b1;
                if ($urandom_range(0, 1) == 1) prog[n-1][28] = 1'b1;
            end
            load(prog);
            run_prog($sformatf("rand%0d", r), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
